// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipe: load-use, branch-operand and
// long-op (mult/div) interlocks, memory-wait freeze, and D/E forwarding selects.
module hazard_scoreboard #(
    parameter int REG_AW             = 5,
    parameter int LAT_W              = 6,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic              uses_rs_d,
    input  logic              uses_rt_d,
    input  logic [REG_AW-1:0] dst_d,
    input  logic              reg_we_d,
    input  logic              long_d,
    input  logic [LAT_W-1:0]  long_lat_d,
    input  logic [1:0]        branch_d,
    input  logic [1:0]        jump_d,
    input  logic              pc_src_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] reg_write_addr_e,
    input  logic              reg_we_e,
    input  logic              mem_to_reg_e,
    input  logic [REG_AW-1:0] reg_write_addr_m,
    input  logic              reg_we_m,
    input  logic              mem_to_reg_m,
    input  logic [REG_AW-1:0] reg_write_addr_w,
    input  logic              reg_we_w,
    input  logic              mem_wait,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              stall_w,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        forward_a_d,
    output logic [1:0]        forward_b_d,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              long_busy,
    output logic              long_wb,
    output logic [REG_AW-1:0] long_dst,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] long_dst_q, long_dst_d;

    logic in_busy, in_wb, issue;
    logic lw_stall, branch_stall, long_stall;
    logic stall_core, stall_mem;

    // Producer match: same address, producer writes, and $0 excluded when hardwired.
    function automatic logic hit(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] wr,
                                 input logic              en);
        return en && (src == wr) && (!ZERO_REG_HARDWIRED || (src != '0));
    endfunction

    // Reset masks the scoreboard immediately so an aborted op has no visible effect.
    assign in_busy = (state_q == ST_BUSY) && !reset;
    assign in_wb   = (state_q == ST_WB) && !reset;

    assign lw_stall =
        hit(rs_d, reg_write_addr_e, uses_rs_d & mem_to_reg_e) |
        hit(rt_d, reg_write_addr_e, uses_rt_d & mem_to_reg_e);

    assign branch_stall = ((branch_d != 2'b00) | jump_d[1]) & (
        hit(rs_d, reg_write_addr_e, uses_rs_d & reg_we_e) |
        hit(rt_d, reg_write_addr_e, uses_rt_d & reg_we_e) |
        hit(rs_d, reg_write_addr_m, uses_rs_d & reg_we_m & mem_to_reg_m) |
        hit(rt_d, reg_write_addr_m, uses_rt_d & reg_we_m & mem_to_reg_m));

    // RAW on the pending result, WAW on its destination, or a second long op.
    assign long_stall = in_busy & (
        hit(rs_d, long_dst_q, uses_rs_d) |
        hit(rt_d, long_dst_q, uses_rt_d) |
        hit(dst_d, long_dst_q, reg_we_d) |
        long_d);

    // if-form so an unknown term falls through to the de-asserted default.
    always_comb begin
        stall_core = 1'b0;
        stall_mem  = 1'b0;
        if (lw_stall | branch_stall | long_stall | mem_wait) stall_core = 1'b1;
        if (mem_wait) stall_mem = 1'b1;
    end

    assign stall_f = stall_core;
    assign stall_d = stall_core;
    assign stall_e = stall_mem;
    assign stall_m = stall_mem;
    assign stall_w = stall_mem;
    assign flush_e = stall_core & ~stall_mem;
    assign flush_d = (pc_src_d | (jump_d != 2'b00)) & ~stall_core;

    assign issue = long_d & ~stall_core;

    always_comb begin
        forward_a_d = 2'b00;
        forward_b_d = 2'b00;
        if (hit(rs_d, reg_write_addr_m, uses_rs_d & reg_we_m))  forward_a_d = 2'b10;
        else if (hit(rs_d, long_dst_q, uses_rs_d & in_wb))      forward_a_d = 2'b11;
        if (hit(rt_d, reg_write_addr_m, uses_rt_d & reg_we_m))  forward_b_d = 2'b10;
        else if (hit(rt_d, long_dst_q, uses_rt_d & in_wb))      forward_b_d = 2'b11;
    end

    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (hit(rs_e, reg_write_addr_m, reg_we_m))      forward_a_e = 2'b10;
        else if (hit(rs_e, reg_write_addr_w, reg_we_w)) forward_a_e = 2'b01;
        else if (hit(rs_e, long_dst_q, in_wb))          forward_a_e = 2'b11;
        if (hit(rt_e, reg_write_addr_m, reg_we_m))      forward_b_e = 2'b10;
        else if (hit(rt_e, reg_write_addr_w, reg_we_w)) forward_b_e = 2'b01;
        else if (hit(rt_e, long_dst_q, in_wb))          forward_b_e = 2'b11;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        long_dst_d = long_dst_q;
        unique case (state_q)
            ST_IDLE, ST_WB: begin
                if (issue) begin
                    state_d    = ST_BUSY;
                    cnt_d      = (long_lat_d == '0) ? LAT_W'(1) : long_lat_d;
                    long_dst_d = dst_d;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Counter runs through mem_wait so the writeback slot stays fixed.
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q <= LAT_W'(1)) state_d = ST_WB;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            long_dst_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            long_dst_q <= long_dst_d;
        end
    end

    assign long_busy   = in_busy;
    assign long_wb     = in_wb;
    assign long_dst    = reset ? '0 : long_dst_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard controller for the 5-stage MIPS core that also tracks one variable-latency execution unit (mult/div) and a data-memory wait signal. It issues stall/flush controls for F/D/E/M/W and forwarding selects for D and E. A one-entry scoreboard holds the destination and remaining latency of the outstanding long operation. It sits beside the datapath and drives the pipeline-register enables/clears and the forwarding muxes.

## Interface
- REG_AW, 5: register address width.
- LAT_W, 6: width of the long-op latency field/counter.
- ZERO_REG_HARDWIRED, 1: if 1, address 0 never matches for forwarding or stalls.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rs_d, rt_d  in  REG_AW  decode source addresses
- uses_rs_d, uses_rt_d  in  1  decode instruction actually reads rs/rt
- dst_d  in  REG_AW  decode destination address
- reg_we_d  in  1  decode instruction writes a register (normal path)
- long_d  in  1  decode instruction is a long-latency op
- long_lat_d  in  LAT_W  its latency in cycles (0 treated as 1)
- branch_d  in  2 ; jump_d  in  2 ; pc_src_d  in  1  control-flow info in D
- rs_e, rt_e, reg_write_addr_e  in  REG_AW ; reg_we_e, mem_to_reg_e  in  1
- reg_write_addr_m  in  REG_AW ; reg_we_m, mem_to_reg_m  in  1
- reg_write_addr_w  in  REG_AW ; reg_we_w  in  1
- mem_wait  in  1  data memory not ready; freezes whole pipe
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1  hold stage register
- flush_d, flush_e  out  1  clear stage register to bubble
- forward_a_d, forward_b_d  out  2  00 regfile, 10 M-stage, 11 long result
- forward_a_e, forward_b_e  out  2  00 regfile, 01 W, 10 M, 11 long result
- long_busy  out  1  state BUSY
- long_wb  out  1  one-cycle write strobe for long result
- long_dst  out  REG_AW  destination of outstanding/completing long op

## Operation
- A source "matches" stage X iff address equal, X's write enable high, and (ZERO_REG_HARDWIRED=0 or address≠0). D sources match only if their uses_* bit is 1.
- FSM: IDLE, BUSY, WB. Registers: state, cnt (LAT_W), long_dst.
- issue = long_d & ~stall_d. On issue: cnt ← max(long_lat_d,1), long_dst ← dst_d, state ← BUSY.
- BUSY: cnt decrements each cycle (independent of mem_wait); when cnt==1 → WB next.
- WB: long_wb=1 for that cycle; next state BUSY if issue, else IDLE.
- lw_stall: mem_to_reg_e and a D source equals reg_write_addr_e.
- branch_stall: (branch_d≠0 or jump_d[1]) and a D source matches E (reg_we_e), or matches M with mem_to_reg_m.
- long_stall: state==BUSY and (D source == long_dst, or reg_we_d & dst_d==long_dst, or long_d).
- stall_d = stall_f = lw_stall | branch_stall | long_stall | mem_wait. stall_e = stall_m = stall_w = mem_wait.
- flush_e = stall_d & ~mem_wait. flush_d = (pc_src_d | jump_d≠0) & ~stall_d.
- E forwarding priority per operand: M (10) > W (01) > long (11, only in WB with match to long_dst) > 00. D forwarding: M (10) > long (11) > 00.
- X on any stall term resolves stall outputs to 0.

## Timing
- Reset: state IDLE, cnt 0, long_dst 0; all outputs 0 during and after reset until inputs dictate. Reset mid-BUSY/WB aborts; long_wb not asserted.
- Issue sampled at edge k: long_busy high cycles k+1..k+lat, long_wb high cycle k+lat+1, long_busy low that cycle.
- Issue in WB cycle accepted (back-to-back); issue in BUSY never happens (long_stall).
- mem_wait blocks issue (stall_d=1) but does not freeze the counter; long_wb still fires on schedule.
- Stall/forward outputs combinational from current inputs and state; no added latency.

## Test plan
- Load-use: mem_to_reg_e=1, reg_write_addr_e=8, rs_d=8, uses_rs_d=1 → stall_f=stall_d=flush_e=1 one cycle; same with uses_rs_d=0 → all 0.
- Long op: issue lat=4 dst=9 at edge 0 → long_busy cycles 1–4, long_wb cycle 5; D reading $9 stalls cycles 1–4, cycle 5 forward_a_d=11, stall_d=0.
- Back-to-back long: second long_d in BUSY stalls; presented in WB → accepted, long_busy high next cycle with new long_dst.
- mem_wait=1 during BUSY: all five stalls 1, flush_e=0, flush_d=0 with pc_src_d=1; long_wb still at scheduled cycle.
- Branch: branch_d=01, rs_d=5, reg_we_e=1, reg_write_addr_e=5 → stall_d=1, flush_d=0 despite pc_src_d=1; next cycle match in M (not load) → forward_a_d=10, no stall.
- Reset asserted cycle 2 of lat=6 op → long_busy=0, long_wb never asserted, rs_d=long_dst no longer stalls.
